alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder for the MIPS pipeline.
- Decodes ALUOp and FunctionField into ALUCtrl in the ID/EX boundary stage.
- Adds a multi-cycle sequencer for MULT/MULTU/DIV/DIVU that runs a cycle counter and asserts Stall to hold the pipeline until the operation completes.

Parameters:
- ALUOP_W, 5, width of ALUOp.
- FUNCT_W, 6, width of FunctionField; must be >= 6.
- CTRL_W, 6, width of ALUCtrl; must be >= 6.
- MUL_CYCLES, 4, busy cycles for MULT/MULTU; >= 1.
- DIV_CYCLES, 32, busy cycles for DIV/DIVU; >= 1.
- CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- Clk, input, 1, rising-edge clock.
- Rst, input, 1, asynchronous active-low reset.
- In_Valid, input, 1, ALUOp/FunctionField valid this cycle.
- ALUOp, input, ALUOP_W, main-control ALU opcode.
- FunctionField, input, FUNCT_W, instruction funct field.
- Flush, input, 1, synchronous pipeline flush.
- In_Ready, output, 1, decoder can accept In_Valid.
- ALUCtrl, output, CTRL_W, registered ALU control code.
- Out_Valid, output, 1, ALUCtrl valid.
- Illegal, output, 1, registered; undefined R-type funct seen.
- MD_Start, output, 1, one-cycle pulse launching the mul/div unit.
- MD_Busy, output, 1, multi-cycle operation in progress.
- MD_Done, output, 1, one-cycle completion pulse.
- Stall, output, 1, pipeline hold request.

Behaviour:
- Reset (Rst=0, async):
  - ALUCtrl=0, Out_Valid=0, Illegal=0, MD_Start=0, MD_Busy=0, MD_Done=0, counter=0, state=IDLE.
  - In_Ready=1 and Stall=0 (combinational from state).
- Decode (all values zero-extended to CTRL_W):
  - ALUOp=0 -> 2 (ADD).
  - ALUOp=1 -> 6 (SUB).
  - ALUOp=2 -> decode on funct: 0x20 -> 2, 0x22 -> 6, 0x24 -> 0, 0x25 -> 1, 0x2A -> 7, 0x18 -> 0x18, 0x19 -> 0x19, 0x1A -> 0x1A, 0x1B -> 0x1B.
  - ALUOp=2 with any other funct -> ALUCtrl=0x3F and Illegal=1.
  - ALUOp>=3 -> ALUCtrl=ALUOp (direct immediate-op encoding).
  - Only the low 6 funct bits are decoded; upper bits are ignored.
- Latency: an accepted input (In_Valid & In_Ready) registers ALUCtrl, Illegal and Out_Valid=1 on the next edge. With no accepted input, Out_Valid=0 next cycle and ALUCtrl holds its value.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accepted funct 0x18/0x19 with ALUOp=2 -> MUL, counter=MUL_CYCLES-1, MD_Start=1 for one cycle.
  - IDLE: accepted funct 0x1A/0x1B with ALUOp=2 -> DIV, counter=DIV_CYCLES-1, MD_Start=1 for one cycle.
  - MUL/DIV: counter decrements each cycle; at counter=0 -> DONE.
  - DONE: MD_Done=1 for exactly one cycle -> IDLE.
  - MD_Busy=1 in MUL, DIV and DONE.
- Stall and In_Ready:
  - Stall=1 and In_Ready=0 in MUL and DIV; both combinational from state.
  - In DONE, Stall=0 and In_Ready=1, so a new input may be accepted in the same cycle MD_Done pulses.
  - In_Valid while In_Ready=0 is ignored; upstream holds it (Stall).
- Cycle counts: Stall is high for exactly N cycles after the accept edge (N = MUL_CYCLES or DIV_CYCLES). MD_Done appears N+1 cycles after the accept edge.
- Flush (synchronous, highest priority after reset):
  - Next edge: state=IDLE, Out_Valid=0, Illegal=0, MD_Busy=0, counter=0, no MD_Done.
  - ALUCtrl holds its value.
  - Flush together with In_Valid: the input is dropped.
- Reset mid-operation: immediate return to reset values; no MD_Done is generated.
- Back-to-back multi-cycle ops: accepting a new mul/div while in DONE goes directly to MUL/DIV with a fresh MD_Start.

Test Plan:
1. Reset, then In_Valid=1, ALUOp=2, funct=0x22 -> next edge ALUCtrl=6, Out_Valid=1, Illegal=0, Stall stays 0.
2. ALUOp=2, funct=0x3F -> ALUCtrl=0x3F, Illegal=1. Then ALUOp=7 -> ALUCtrl=7, Illegal=0.
3. MULT (ALUOp=2, funct=0x18), MUL_CYCLES=4:
   - MD_Start pulses one cycle; Stall=1 for exactly 4 cycles; In_Valid ignored meanwhile.
   - MD_Done pulses on cycle 5; In_Ready=1 on cycle 5.
4. DIV followed immediately by MULTU presented during DONE:
   - DIV runs DIV_CYCLES stall cycles.
   - MULTU is accepted in DONE; a second MD_Start follows with no idle gap.
5. Flush asserted at cycle 10 of a DIV -> next edge MD_Busy=0, Stall=0, Out_Valid=0, and MD_Done never pulses.
6. Rst driven low asynchronously mid-MUL, between clock edges -> all outputs at reset values immediately. After release, ALUOp=0 -> ALUCtrl=2 one cycle later.

Source files
------------

// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_seq
// Description : Registered MIPS ALU control decoder with a mul/div stall sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_seq #(
    parameter int ALUOP_W    = 5,
    parameter int FUNCT_W    = 6,
    parameter int CTRL_W     = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               In_Valid,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] FunctionField,
    input  logic               Flush,
    output logic               In_Ready,
    output logic [CTRL_W-1:0]  ALUCtrl,
    output logic               Out_Valid,
    output logic               Illegal,
    output logic               MD_Start,
    output logic               MD_Busy,
    output logic               MD_Done,
    output logic               Stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CTRL_W-1:0] c_and     = CTRL_W'(6'h00);
    localparam logic [CTRL_W-1:0] c_or      = CTRL_W'(6'h01);
    localparam logic [CTRL_W-1:0] c_add     = CTRL_W'(6'h02);
    localparam logic [CTRL_W-1:0] c_sub     = CTRL_W'(6'h06);
    localparam logic [CTRL_W-1:0] c_slt     = CTRL_W'(6'h07);
    localparam logic [CTRL_W-1:0] c_illegal = CTRL_W'(6'h3F);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [5:0]         w_funct;
    logic [CTRL_W-1:0]  w_dec_ctrl;
    logic               w_dec_illegal;
    logic               w_dec_mul;
    logic               w_dec_div;
    logic               w_in_ready;
    logic               w_accept;

    assign w_funct = FunctionField[5:0];

    always_comb begin
        w_dec_ctrl    = c_add;
        w_dec_illegal = 1'b0;
        w_dec_mul     = 1'b0;
        w_dec_div     = 1'b0;
        if (ALUOp == ALUOP_W'(0)) begin
            w_dec_ctrl = c_add;
        end else if (ALUOp == ALUOP_W'(1)) begin
            w_dec_ctrl = c_sub;
        end else if (ALUOp == ALUOP_W'(2)) begin
            case (w_funct)
                6'h20:   w_dec_ctrl = c_add;
                6'h22:   w_dec_ctrl = c_sub;
                6'h24:   w_dec_ctrl = c_and;
                6'h25:   w_dec_ctrl = c_or;
                6'h2A:   w_dec_ctrl = c_slt;
                6'h18, 6'h19: begin
                    w_dec_ctrl = CTRL_W'(w_funct);
                    w_dec_mul  = 1'b1;
                end
                6'h1A, 6'h1B: begin
                    w_dec_ctrl = CTRL_W'(w_funct);
                    w_dec_div  = 1'b1;
                end
                default: begin
                    w_dec_ctrl    = c_illegal;
                    w_dec_illegal = 1'b1;
                end
            endcase
        end else begin
            // Immediate-type ops carry their ALU code directly in ALUOp.
            w_dec_ctrl = CTRL_W'(ALUOp);
        end
    end

    assign w_in_ready = (state_q != S_MUL) && (state_q != S_DIV);
    assign w_accept   = In_Valid && w_in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = 1'b0;
        illegal_d = illegal_q;
        start_d   = 1'b0;
        if (Flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                S_MUL, S_DIV: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept, so back-to-back mul/div has no gap.
                    state_d = S_IDLE;
                    if (w_accept) begin
                        ctrl_d    = w_dec_ctrl;
                        illegal_d = w_dec_illegal;
                        valid_d   = 1'b1;
                        if (w_dec_mul) begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            start_d = 1'b1;
                        end else if (w_dec_div) begin
                            state_d = S_DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            start_d = 1'b1;
                        end
                    end
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign In_Ready  = w_in_ready;
    assign Stall     = !w_in_ready;
    assign ALUCtrl   = ctrl_q;
    assign Out_Valid = valid_q;
    assign Illegal   = illegal_q;
    assign MD_Start  = start_q;
    assign MD_Busy   = busy_q;
    assign MD_Done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_seq
// Description : Directed self-checking bench for alu_control_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_seq;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       In_Valid = 1'b0;
    logic [4:0] ALUOp = '0;
    logic [5:0] FunctionField = '0;
    logic       Flush = 1'b0;
    logic       In_Ready;
    logic [5:0] ALUCtrl;
    logic       Out_Valid;
    logic       Illegal;
    logic       MD_Start;
    logic       MD_Busy;
    logic       MD_Done;
    logic       Stall;

    int passed = 0;
    int total  = 0;

    logic [12:0] obs;
    assign obs = {In_Ready, ALUCtrl, Out_Valid, Illegal, MD_Start, MD_Busy, MD_Done, Stall};

    always #5 Clk = ~Clk;

    alu_control_seq #(
        .ALUOP_W(5), .FUNCT_W(6), .CTRL_W(6),
        .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)
    ) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .ALUOp(ALUOp),
        .FunctionField(FunctionField), .Flush(Flush), .In_Ready(In_Ready),
        .ALUCtrl(ALUCtrl), .Out_Valid(Out_Valid), .Illegal(Illegal),
        .MD_Start(MD_Start), .MD_Busy(MD_Busy), .MD_Done(MD_Done), .Stall(Stall)
    );

    // Field order: ready, ctrl, out_valid, illegal, start, busy, done, stall
    function automatic logic [12:0] ev(input logic rdy, input logic [5:0] ctrl,
                                       input logic v, input logic ill, input logic st,
                                       input logic bsy, input logic dn, input logic stl);
        return {rdy, ctrl, v, ill, st, bsy, dn, stl};
    endfunction

    task automatic chkv(input string tag, input logic [12:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h (rdy,ctrl,vld,ill,start,busy,done,stall)",
                   tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [5:0] fn);
        In_Valid      = v;
        ALUOp         = op;
        FunctionField = fn;
    endtask

    logic [4:0] t_op  [9] = '{5'd0,  5'd1,  5'd2,  5'd2,  5'd2,  5'd2,  5'd2,  5'd31, 5'd3};
    logic [5:0] t_fn  [9] = '{6'h3F, 6'h00, 6'h20, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h18};
    logic [5:0] t_ctl [9] = '{6'h02, 6'h06, 6'h02, 6'h00, 6'h01, 6'h07, 6'h3F, 6'h1F, 6'h03};
    logic       t_ill [9] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};

    logic seen_done;

    initial begin
        #2 Rst = 1'b0;
        tick();
        tick();
        chkv("reset_state", ev(1, 6'h00, 0, 0, 0, 0, 0, 0));
        Rst = 1'b1;
        tick();

        // R-type SUB
        drive(1, 5'd2, 6'h22);
        tick();
        chkv("sub_decode", ev(1, 6'h06, 1, 0, 0, 0, 0, 0));
        drive(0, 5'd0, 6'h00);
        tick();
        chkv("idle_hold_ctrl", ev(1, 6'h06, 0, 0, 0, 0, 0, 0));

        // Illegal funct, then immediate op clears Illegal
        drive(1, 5'd2, 6'h3F);
        tick();
        chkv("illegal_funct", ev(1, 6'h3F, 1, 1, 0, 0, 0, 0));
        drive(1, 5'd7, 6'h00);
        tick();
        chkv("imm_op7", ev(1, 6'h07, 1, 0, 0, 0, 0, 0));

        // Back-to-back decode table
        for (int i = 0; i < 9; i++) begin
            drive(1, t_op[i], t_fn[i]);
            tick();
            chkv($sformatf("decode_tbl_%0d", i), ev(1, t_ctl[i], 1, t_ill[i], 0, 0, 0, 0));
        end
        drive(0, 5'd0, 6'h00);
        tick();

        // MULT: stall 4 cycles, Done on cycle 5; ADD held upstream during stall
        drive(1, 5'd2, 6'h18);
        tick();
        chkv("mult_c1", ev(0, 6'h18, 1, 0, 1, 1, 0, 1));
        drive(1, 5'd0, 6'h00);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chkv($sformatf("mult_c%0d", c), ev(0, 6'h18, 0, 0, 0, 1, 0, 1));
        end
        tick();
        chkv("mult_done", ev(1, 6'h18, 0, 0, 0, 1, 1, 0));
        tick();
        chkv("accept_in_done", ev(1, 6'h02, 1, 0, 0, 0, 0, 0));
        drive(0, 5'd0, 6'h00);
        tick();

        // DIV then MULTU accepted in DONE
        drive(1, 5'd2, 6'h1A);
        tick();
        chkv("div_c1", ev(0, 6'h1A, 1, 0, 1, 1, 0, 1));
        drive(0, 5'd0, 6'h00);
        for (int c = 2; c <= 32; c++) begin
            tick();
            chkv($sformatf("div_c%0d", c), ev(0, 6'h1A, 0, 0, 0, 1, 0, 1));
        end
        tick();
        chkv("div_done", ev(1, 6'h1A, 0, 0, 0, 1, 1, 0));
        drive(1, 5'd2, 6'h19);
        tick();
        chkv("multu_c1", ev(0, 6'h19, 1, 0, 1, 1, 0, 1));
        drive(0, 5'd0, 6'h00);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chkv($sformatf("multu_c%0d", c), ev(0, 6'h19, 0, 0, 0, 1, 0, 1));
        end
        tick();
        chkv("multu_done", ev(1, 6'h19, 0, 0, 0, 1, 1, 0));
        tick();
        chkv("multu_idle", ev(1, 6'h19, 0, 0, 0, 0, 0, 0));

        // DIVU flushed at cycle 10
        drive(1, 5'd2, 6'h1B);
        tick();
        chkv("divu_c1", ev(0, 6'h1B, 1, 0, 1, 1, 0, 1));
        drive(0, 5'd0, 6'h00);
        for (int c = 2; c <= 10; c++) tick();
        chkv("divu_c10", ev(0, 6'h1B, 0, 0, 0, 1, 0, 1));
        Flush = 1'b1;
        drive(1, 5'd0, 6'h00);
        tick();
        chkv("flush_div", ev(1, 6'h1B, 0, 0, 0, 0, 0, 0));
        tick();
        chkv("flush_drops_input", ev(1, 6'h1B, 0, 0, 0, 0, 0, 0));
        Flush = 1'b0;
        drive(0, 5'd0, 6'h00);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (MD_Done === 1'b1) seen_done = 1'b1;
        end
        chkb("no_done_after_flush", seen_done, 1'b0);

        // Async reset mid-MUL
        drive(1, 5'd2, 6'h18);
        tick();
        drive(0, 5'd0, 6'h00);
        tick();
        tick();
        chkv("mul_before_rst", ev(0, 6'h18, 0, 0, 0, 1, 0, 1));
        #2 Rst = 1'b0;
        #1;
        chkv("async_rst_immediate", ev(1, 6'h00, 0, 0, 0, 0, 0, 0));
        tick();
        chkv("rst_held", ev(1, 6'h00, 0, 0, 0, 0, 0, 0));
        Rst = 1'b1;
        drive(1, 5'd0, 6'h00);
        tick();
        chkv("post_rst_add", ev(1, 6'h02, 1, 0, 0, 0, 0, 0));
        drive(0, 5'd0, 6'h00);
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (MD_Done === 1'b1) seen_done = 1'b1;
        end
        chkb("no_done_after_rst", seen_done, 1'b0);
        chkv("final_idle", ev(1, 6'h02, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
